ins_fetch_pq: RTL and testbench

//  Parametrised instruction-fetch stage with an in-order prefetch queue. Owns the fetch PC.

---
 rtl/if_pkg.sv | 14 +
 rtl/ins_fetch_pq_if.sv | 48 ++++
 rtl/pq_entry_ram.sv | 63 ++++++
 rtl/ins_fetch_pq.sv | 127 ++++++++++++
 tb/tb_ins_fetch_pq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: the bubble instruction, the PC step
// and the prefetch queue entry states.
package if_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          INST_BYTES = 4;

    typedef enum logic [1:0] {
        E_FREE = 2'd0,
        E_PEND = 2'd1,
        E_FULL = 2'd2
    } entry_state_e;

endpackage

// File: rtl/ins_fetch_pq_if.sv
// Fetch-stage bus: redirect input, ROM req/gnt/rvalid channel and
// the valid/ready instruction hand-off towards if_id.
interface ins_fetch_pq_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          jump_en_i;
    logic [AW-1:0] jump_addr_i;
    logic          rom_req_o;
    logic [AW-1:0] rom_addr_o;
    logic          rom_gnt_i;
    logic          rom_rvalid_i;
    logic [DW-1:0] rom_rdata_i;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic [AW-1:0] inst_addr_o;
    logic [DW-1:0] inst_o;

    modport master (
        input  jump_en_i,
        input  jump_addr_i,
        output rom_req_o,
        output rom_addr_o,
        input  rom_gnt_i,
        input  rom_rvalid_i,
        input  rom_rdata_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_addr_o,
        output inst_o
    );

    modport slave (
        output jump_en_i,
        output jump_addr_i,
        input  rom_req_o,
        input  rom_addr_o,
        output rom_gnt_i,
        output rom_rvalid_i,
        output rom_rdata_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_addr_o,
        input  inst_o
    );

endinterface

// File: rtl/pq_entry_ram.sv
// Prefetch queue storage: per-entry address, data and state with
// independent alloc/fill/pop write ports and a global clear.
module pq_entry_ram
    import if_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          alloc_en,
    input  logic [PW-1:0] alloc_idx,
    input  logic [AW-1:0] alloc_addr,
    input  logic          fill_en,
    input  logic [PW-1:0] fill_idx,
    input  logic [DW-1:0] fill_data,
    input  logic          pop_en,
    input  logic [PW-1:0] pop_idx,
    input  logic [PW-1:0] head_idx,
    output entry_state_e  head_state,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    entry_state_e  state [DEPTH];
    logic [AW-1:0] addr  [DEPTH];
    logic [DW-1:0] data  [DEPTH];

    // alloc/fill/pop always target entries in different states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= E_FREE;
                addr[i]  <= '0;
                data[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= E_FREE;
            end
        end else begin
            if (alloc_en) begin
                state[alloc_idx] <= E_PEND;
                addr[alloc_idx]  <= alloc_addr;
            end
            if (fill_en) begin
                state[fill_idx] <= E_FULL;
                data[fill_idx]  <= fill_data;
            end
            if (pop_en) begin
                state[pop_idx] <= E_FREE;
            end
        end
    end

    assign head_state = state[head_idx];
    assign head_addr  = addr[head_idx];
    assign head_data  = data[head_idx];

endmodule

// File: rtl/ins_fetch_pq.sv
// Instruction fetch stage with in-order prefetch queue; owns the
// fetch PC and drops in-flight reads across redirects.
module ins_fetch_pq
    import if_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] NOP_INST = DW'(if_pkg::NOP_INST)
) (
    input logic           clk,
    input logic           rst,
    ins_fetch_pq_if.master bus
);

    localparam int            PW    = $clog2(DEPTH);
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] alloc_cnt;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] drop_cnt;

    entry_state_e  head_state;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    logic          jump;
    logic          issue;
    logic          resp;
    logic          resp_take;
    logic          drop_resp;
    logic          fill;
    logic          pop;
    logic          head_full;
    logic [CW:0]   used;
    logic [CW:0]   drop_sum;

    assign jump      = bus.jump_en_i;
    assign used      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    assign resp      = bus.rom_rvalid_i;
    assign resp_take = resp && (drop_cnt != '0 || pend_cnt != '0);
    assign drop_resp = resp && (drop_cnt != '0);
    assign fill      = resp && (drop_cnt == '0)
                     && (pend_cnt != '0) && !jump;
    assign head_full = (head_state == E_FULL);
    assign pop       = head_full && bus.inst_ready_i && !jump;
    assign issue     = bus.rom_req_o && bus.rom_gnt_i;

    // reads already in flight at a redirect become drops
    assign drop_sum  = {1'b0, drop_cnt} + {1'b0, pend_cnt}
                     - {{CW{1'b0}}, resp_take};

    assign bus.rom_req_o    = rst && !jump && (used < LIMIT);
    assign bus.rom_addr_o   = fetch_pc;
    assign bus.inst_valid_o = head_full;
    assign bus.inst_addr_o  = head_addr;
    assign bus.inst_o       = head_full ? head_data : NOP_INST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (jump) begin
            fetch_pc  <= {bus.jump_addr_i[AW-1:2], 2'b00};
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= drop_sum[CW-1:0];
        end else begin
            if (issue) begin
                fetch_pc  <= fetch_pc + AW'(INST_BYTES);
                alloc_ptr <= alloc_ptr + PW'(1);
            end
            if (fill) fill_ptr <= fill_ptr + PW'(1);
            if (pop) head_ptr <= head_ptr + PW'(1);
            if (drop_resp) drop_cnt <= drop_cnt - CW'(1);
            alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
            pend_cnt  <= pend_cnt + CW'(issue) - CW'(fill);
        end
    end

    pq_entry_ram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .clear      (jump),
        .alloc_en   (issue),
        .alloc_idx  (alloc_ptr),
        .alloc_addr (fetch_pc),
        .fill_en    (fill),
        .fill_idx   (fill_ptr),
        .fill_data  (bus.rom_rdata_i),
        .pop_en     (pop),
        .pop_idx    (head_ptr),
        .head_idx   (head_ptr),
        .head_state (head_state),
        .head_addr  (head_addr),
        .head_data  (head_data)
    );

    a_no_orphan_rvalid: assert property (
        @(posedge clk) disable iff (!rst)
        !(resp && drop_cnt == '0 && pend_cnt == '0)
    );

    a_outstanding_bound: assert property (
        @(posedge clk) disable iff (!rst)
        used <= LIMIT
    );

endmodule

// File: tb/tb_ins_fetch_pq.sv
// Directed bench for ins_fetch_pq: ROM model with variable latency
// and an expected-PC scoreboard on every popped instruction.
module tb_ins_fetch_pq;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;

    logic clk;
    logic rst;

    ins_fetch_pq_if #(.AW(32), .DW(32)) b ();

    ins_fetch_pq #(
        .AW       (32),
        .DW       (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .NOP_INST (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          npop = 0;
    logic [31:0] exp_pc = 0;
    rd_t         rq[$];

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_iaddr;
    logic [31:0] s_inst;
    logic        s_issue;
    logic        s_pop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        b.jump_en_i    = 1'b0;
        b.jump_addr_i  = '0;
        b.rom_gnt_i    = 1'b0;
        b.rom_rvalid_i = 1'b0;
        b.rom_rdata_i  = '0;
        b.inst_ready_i = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"}, b.rom_req_o, 0);
        chk({tag, "_valid"}, b.inst_valid_o, 0);
        chk({tag, "_inst"}, b.inst_o, NOP);
        chk({tag, "_iaddr"}, b.inst_addr_o, 0);
    endtask

    // called at a negedge, returns at a negedge with rst released
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        rq.delete();
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst      = 1'b1;
        cyc      = 0;
        last_due = -1;
        exp_pc   = 0;
    endtask

    task automatic cycle(input logic jmp, input logic [31:0] ja,
                         input logic g, input logic rdy,
                         input int lat);
        int due;
        b.jump_en_i    = jmp;
        b.jump_addr_i  = ja;
        b.rom_gnt_i    = g;
        b.inst_ready_i = rdy;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            b.rom_rvalid_i = 1'b1;
            b.rom_rdata_i  = ~rq[0].addr;
            void'(rq.pop_front());
        end else begin
            b.rom_rvalid_i = 1'b0;
            b.rom_rdata_i  = '0;
        end
        #1;
        s_req   = b.rom_req_o;
        s_addr  = b.rom_addr_o;
        s_valid = b.inst_valid_o;
        s_iaddr = b.inst_addr_o;
        s_inst  = b.inst_o;
        s_issue = s_req && g;
        if (s_issue) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            rq.push_back('{s_addr, due});
            last_due = due;
        end
        s_pop = s_valid && rdy && !jmp;
        if (s_pop) begin
            chk("sb_addr", s_iaddr, exp_pc);
            chk("sb_data", s_inst, ~exp_pc);
            exp_pc += 32'd4;
            npop++;
        end else if (!s_valid) begin
            chk("sb_nop", s_inst, NOP);
        end
        if (jmp) exp_pc = {ja[31:2], 2'b00};
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_first(input string tag,
                              input logic [31:0] exp,
                              input int lat);
        int n = 0;
        do begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, lat);
            n++;
        end while (!s_valid && n < 40);
        chk({tag, "_seen"}, s_valid, 1);
        chk({tag, "_addr"}, s_iaddr, exp);
    endtask

    initial begin
        int n;
        int p0;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);

        // 1: streaming, latency 1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (i < 4) begin
                chk("t1_req", s_req, 1);
                chk("t1_raddr", s_addr, 32'(i * 4));
            end
            if (i >= 2) begin
                chk("t1_valid", s_valid, 1);
                chk("t1_iaddr", s_iaddr, 32'(4 * (i - 2)));
            end else begin
                chk("t1_lat", s_valid, 0);
            end
        end

        // 2: stall fills the queue, release drains it
        do_reset();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1);
            n += int'(s_issue);
        end
        chk("t2_issued", n, 4);
        chk("t2_req_full", s_req, 0);
        chk("t2_head", s_iaddr, 0);
        chk("t2_hvalid", s_valid, 1);
        chk("t2_hinst", s_inst, 32'hFFFF_FFFF);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1);
            n += int'(s_pop);
            if (i == 0) chk("t2_req_pop", s_req, 0);
            if (i == 1) begin
                chk("t2_resume", s_req, 1);
                chk("t2_raddr", s_addr, 32'h10);
            end
        end
        chk("t2_pops", n, 4);

        // 3: redirect with reads in flight, latency 3
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);
        cycle(1'b1, 32'h103, 1'b1, 1'b1, 3);
        chk("t3_req_jmp", s_req, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);
        chk("t3_req", s_req, 1);
        chk("t3_raddr", s_addr, 32'h100);
        wait_first("t3_first", 32'h100, 3);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);

        // 4: redirect together with rvalid and a pop
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 2);
        cycle(1'b1, 32'h40, 1'b1, 1'b1, 2);
        chk("t4_vjmp", s_valid, 1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 2);
        chk("t4_vnext", s_valid, 0);
        chk("t4_raddr", s_addr, 32'h40);
        wait_first("t4_first", 32'h40, 2);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 2);

        // 5: two redirects close together
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);
        cycle(1'b1, 32'h200, 1'b1, 1'b1, 3);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);
        chk("t5_raddr", s_addr, 32'h200);
        cycle(1'b1, 32'h300, 1'b1, 1'b1, 3);
        wait_first("t5_first", 32'h300, 3);
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 3);

        // 6: random gnt/latency/ready with rare redirects
        do_reset();
        p0 = npop;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 50) == 0, $urandom, $urandom % 2,
                  ($urandom % 4) != 0, int'($urandom_range(1, 4)));
        end
        chk("t6_pops", (npop - p0) >= 50, 1);
        #3 rst = 1'b0;
        #1 chk_reset_outs("t6_async");
        idle_inputs();
        do_reset();
        wait_first("t6_after", 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
